// File: rtl/ss_signed_sng.sv
// Signed stochastic number generator.
// Turns N sign-magnitude operands into per-channel (OUT, SIGN) bitstreams.
// Each frame lasts 2^WIDTH-1 cycles and replays the LFSR from SEED. Channel i
// compares its magnitude against a channel-specific rotation of the shared
// LFSR, which decorrelates the channel streams.
// A one-deep pending buffer lets the next operand start with no idle cycle.
module ss_signed_sng #(
    parameter int unsigned             N        = 2,
    parameter int unsigned             WIDTH    = 8,
    parameter logic [WIDTH-1:0]        TAPS     = 8'hB8,
    parameter logic [WIDTH-1:0]        SEED     = 8'd1,
    parameter int unsigned             ROT_STEP = 3
) (
    input  logic                 CLK,
    input  logic                 INIT,
    input  logic                 LOAD,
    input  logic [N*WIDTH-1:0]   MAG,
    input  logic [N-1:0]         SGN,
    output logic                 READY,
    output logic                 VALID,
    output logic                 FRAME_START,
    output logic                 DONE,
    output logic [N-1:0]         OUT,
    output logic [N-1:0]         SIGN
);

    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] RUN  = 1'b1;

    localparam logic [WIDTH-1:0] LAST   = '1;
    localparam logic [WIDTH-1:0] PENULT = LAST - 1'b1;

    logic [0:0]          state;
    logic [WIDTH-1:0]    lfsr;
    logic [WIDTH-1:0]    cnt;
    logic [N*WIDTH-1:0]  act_mag;
    logic                pend;
    logic [N*WIDTH-1:0]  pend_mag;
    logic [N-1:0]        pend_sgn;

    logic                at_end;
    logic                use_pend;
    logic                start;
    logic                to_pend;
    logic [N*WIDTH-1:0]  new_mag;
    logic [N-1:0]        new_sgn;
    logic [WIDTH-1:0]    cmp_lfsr;
    logic [N*WIDTH-1:0]  cmp_mag;
    logic [WIDTH-1:0]    lfsr_next;
    logic [N-1:0]        out_next;
    logic [N-1:0]        sign_next;

    assign READY = (state == IDLE) || !pend;

    // Frame control decode; a frame start evaluates the comparator on SEED and
    // the incoming operand so the first frame cycle needs no extra register stage.
    always_comb begin
        at_end    = (state == RUN) && (cnt == LAST);
        use_pend  = at_end && pend;
        start     = ((state == IDLE) && LOAD) || (at_end && (pend || LOAD));
        to_pend   = (state == RUN) && !at_end && LOAD && !pend;
        new_mag   = use_pend ? pend_mag : MAG;
        new_sgn   = use_pend ? pend_sgn : SGN;
        cmp_lfsr  = start ? SEED : lfsr;
        cmp_mag   = start ? new_mag : act_mag;
        lfsr_next = {cmp_lfsr[WIDTH-2:0], ^(cmp_lfsr & TAPS)};
    end

    for (genvar i = 0; i < N; i++) begin : g_ch
        localparam int unsigned SH = (i * ROT_STEP) % WIDTH;
        logic [2*WIDTH-1:0] dbl;
        assign dbl          = {cmp_lfsr, cmp_lfsr};
        assign out_next[i]  = dbl[2*WIDTH-1-SH -: WIDTH] <= cmp_mag[i*WIDTH +: WIDTH];
        assign sign_next[i] = new_sgn[i] & (|new_mag[i*WIDTH +: WIDTH]);
    end

    // Frame sequencer: state, LFSR, cycle counter and the registered stream outputs.
    always_ff @(posedge CLK) begin
        if (INIT) begin
            state       <= IDLE;
            lfsr        <= SEED;
            cnt         <= '0;
            act_mag     <= '0;
            VALID       <= 1'b0;
            FRAME_START <= 1'b0;
            DONE        <= 1'b0;
            OUT         <= '0;
            SIGN        <= '0;
        end else if (start) begin
            state       <= RUN;
            act_mag     <= new_mag;
            lfsr        <= lfsr_next;
            cnt         <= {{(WIDTH-1){1'b0}}, 1'b1};
            VALID       <= 1'b1;
            FRAME_START <= 1'b1;
            DONE        <= 1'b0;
            OUT         <= out_next;
            SIGN        <= sign_next;
        end else if ((state == RUN) && !at_end) begin
            lfsr        <= lfsr_next;
            cnt         <= cnt + 1'b1;
            FRAME_START <= 1'b0;
            DONE        <= (cnt == PENULT);
            OUT         <= out_next;
        end else if (at_end) begin
            state       <= IDLE;
            lfsr        <= SEED;
            cnt         <= '0;
            VALID       <= 1'b0;
            FRAME_START <= 1'b0;
            DONE        <= 1'b0;
            OUT         <= '0;
            SIGN        <= '0;
        end
    end

    // Pending buffer: holds one accepted operand until the current frame ends.
    always_ff @(posedge CLK) begin
        if (INIT) begin
            pend     <= 1'b0;
            pend_mag <= '0;
            pend_sgn <= '0;
        end else if (use_pend) begin
            pend     <= 1'b0;
        end else if (to_pend) begin
            pend     <= 1'b1;
            pend_mag <= MAG;
            pend_sgn <= SGN;
        end
    end

endmodule

// File: tb/tb_ss_signed_sng.sv
// Self-checking bench for ss_signed_sng: directed scenarios followed by random
// LOAD/INIT traffic, compared against a frame-level reference model.
module tb_ss_signed_sng;

    localparam int N   = 2;
    localparam int W   = 8;
    localparam int F   = 255;
    localparam int ROT = 3;

    logic           clk = 1'b0;
    logic           init;
    logic           load;
    logic [N*W-1:0] mag;
    logic [N-1:0]   sgn;
    logic           ready;
    logic           valid;
    logic           frame_start;
    logic           done;
    logic [N-1:0]   out;
    logic [N-1:0]   sign;

    int n_cmp = 0;
    int n_bad = 0;

    // reference model state
    int         seq [F];
    int         pos;
    bit         pend;
    int         cur_mag [N];
    int         pnd_mag [N];
    bit [N-1:0] cur_sgn;
    bit [N-1:0] pnd_sgn;
    int         ones [N];
    int         both;

    always #5 clk = ~clk;

    ss_signed_sng #(
        .N        (N),
        .WIDTH    (W),
        .TAPS     (8'hB8),
        .SEED     (8'd1),
        .ROT_STEP (ROT)
    ) dut (
        .CLK         (clk),
        .INIT        (init),
        .LOAD        (load),
        .MAG         (mag),
        .SGN         (sgn),
        .READY       (ready),
        .VALID       (valid),
        .FRAME_START (frame_start),
        .DONE        (done),
        .OUT         (out),
        .SIGN        (sign)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: observed %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic int rotl(input int v, input int s);
        return ((v << s) | (v >> (W - s))) & 255;
    endfunction

    function automatic int rand_mag();
        int r;
        r = $urandom_range(0, 9);
        if (r == 0) return 0;
        if (r == 1) return 255;
        return $urandom_range(0, 255);
    endfunction

    task automatic start_from_inputs();
        for (int i = 0; i < N; i++) cur_mag[i] = int'(mag[i*W +: W]);
        cur_sgn = sgn;
        pos = 1;
    endtask

    // Advance the model by one clock edge using the inputs the DUT samples.
    task automatic model_step();
        if (init) begin
            pos  = 0;
            pend = 1'b0;
        end else if (pos == 0) begin
            if (load) start_from_inputs();
        end else if (pos == F) begin
            if (pend) begin
                cur_mag = pnd_mag;
                cur_sgn = pnd_sgn;
                pend    = 1'b0;
                pos     = 1;
            end else if (load) begin
                start_from_inputs();
            end else begin
                pos = 0;
            end
        end else begin
            pos++;
            if (load && !pend) begin
                pend = 1'b1;
                for (int i = 0; i < N; i++) pnd_mag[i] = int'(mag[i*W +: W]);
                pnd_sgn = sgn;
            end
        end
    endtask

    task automatic check_outputs();
        logic [N-1:0] e_out;
        logic [N-1:0] e_sign;
        logic         e_ready;
        bit           all128;
        e_out   = '0;
        e_sign  = '0;
        e_ready = (pos == 0) || !pend;
        if (pos != 0) begin
            for (int i = 0; i < N; i++) begin
                e_out[i]  = rotl(seq[pos-1], (i * ROT) % W) <= cur_mag[i];
                e_sign[i] = cur_sgn[i] && (cur_mag[i] != 0);
            end
        end
        check("ctl", {ready, valid, frame_start, done, sign, out},
              {e_ready, pos != 0, pos == 1, pos == F, e_sign, e_out});
        if (pos == 1) begin
            for (int i = 0; i < N; i++) ones[i] = 0;
            both = 0;
        end
        if (pos != 0) begin
            for (int i = 0; i < N; i++) ones[i] += int'(out[i]);
            if (&out) both++;
        end
        if (pos == F) begin
            all128 = 1'b1;
            for (int i = 0; i < N; i++) begin
                check($sformatf("ones%0d", i), ones[i], cur_mag[i]);
                if (cur_mag[i] != 128) all128 = 1'b0;
            end
            if (all128) check("both_eq_128", both == 128, 0);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        model_step();
        @(negedge clk);
        check_outputs();
    endtask

    task automatic idle(input int n);
        repeat (n) cyc();
    endtask

    task automatic do_load(input int m0, input int m1, input logic [1:0] s);
        mag[W-1:0]   = 8'(m0);
        mag[2*W-1:W] = 8'(m1);
        sgn  = s;
        load = 1'b1;
        cyc();
        load = 1'b0;
    endtask

    initial begin
        int v;
        bit fb;
        v = 1;
        for (int k = 0; k < F; k++) begin
            seq[k] = v;
            fb = ^(v & 'hB8);
            v  = ((v << 1) | int'(fb)) & 255;
        end
        pos = 0; pend = 1'b0; both = 0; cur_sgn = '0; pnd_sgn = '0;
        for (int i = 0; i < N; i++) begin
            cur_mag[i] = 0; pnd_mag[i] = 0; ones[i] = 0;
        end

        init = 1'b1; load = 1'b0; mag = '0; sgn = '0;
        cyc(); cyc();
        init = 1'b0;
        cyc();

        // basic frame
        do_load(128, 64, 2'b00);  idle(256);
        // magnitude extremes and sign forcing
        do_load(0, 255, 2'b11);   idle(256);
        // pending accept, then ignored load while pending is full
        do_load(10, 20, 2'b01);   idle(9);
        do_load(30, 40, 2'b10);   idle(9);
        do_load(50, 60, 2'b11);   idle(520);
        // load accepted on the DONE cycle with nothing pending
        do_load(77, 200, 2'b10);  idle(254);
        do_load(5, 250, 2'b01);   idle(257);
        // abort at frame cycle 100, then a full frame
        do_load(99, 150, 2'b01);  idle(99);
        init = 1'b1; cyc(); init = 1'b0; cyc();
        do_load(33, 222, 2'b11);  idle(257);
        // equal magnitudes must not yield identical streams
        do_load(128, 128, 2'b00); idle(256);

        // random traffic; operands change every cycle, loads and INIT are sparse
        repeat (4000) begin
            for (int i = 0; i < N; i++) mag[i*W +: W] = 8'(rand_mag());
            sgn  = N'($urandom);
            load = ($urandom_range(0, 31) == 0);
            init = ($urandom_range(0, 1499) == 0);
            cyc();
        end
        load = 1'b0; init = 1'b0;
        idle(300);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
